// File: rtl/alu_wb_buffer.sv
// Result FIFO between the ALU writeback port and the writeback arbiter (valid/ack).
// Optional same-cycle bypass of an empty buffer: define ALU_WB_BYPASS_EN.
module alu_wb_buffer #(
  parameter int DEPTH    = 4,
  parameter int ID_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_done,
  input  logic [ID_WIDTH-1:0]       in_id,
  input  logic [31:0]               in_rd,
  output logic                      unit_ready,
  output logic                      wb_valid,
  output logic [ID_WIDTH-1:0]       wb_id,
  output logic [31:0]               wb_rd,
  input  logic                      wb_ack,
  output logic                      overflow,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [ID_WIDTH-1:0] r_id_mem [DEPTH];
  logic [31:0]         r_rd_mem [DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic                r_overflow;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_valid;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

`ifdef ALU_WB_BYPASS_EN
  logic w_bypass;
  assign w_bypass = w_empty & in_done;
  assign w_valid  = ~w_empty | in_done;
  assign wb_id    = w_bypass ? in_id : r_id_mem[r_rd_ptr];
  assign wb_rd    = w_bypass ? in_rd : r_rd_mem[r_rd_ptr];
  // A bypassed result consumed in the same cycle never occupies a slot.
  assign w_push   = in_done & ~w_full & ~(w_bypass & wb_ack);
`else
  assign w_valid  = ~w_empty;
  assign wb_id    = r_id_mem[r_rd_ptr];
  assign wb_rd    = r_rd_mem[r_rd_ptr];
  assign w_push   = in_done & ~w_full;
`endif

  // Only stored entries can be popped; an ack on an empty buffer is ignored.
  assign w_pop = wb_ack & ~w_empty;

  assign wb_valid   = w_valid;
  assign unit_ready = ~w_full;
  assign overflow   = r_overflow;
  assign count      = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_id_mem[i] <= '0;
        r_rd_mem[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_id_mem[r_wr_ptr] <= in_id;
        r_rd_mem[r_wr_ptr] <= in_rd;
        r_wr_ptr           <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (in_done && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Scoreboard bench for alu_wb_buffer; expected results queued at issue, checked by a monitor.
module tb_alu_wb_buffer;

`ifdef ALU_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_done = 1'b0;
  logic [2:0]  in_id = '0;
  logic [31:0] in_rd = '0;
  logic        unit_ready;
  logic        wb_valid;
  logic [2:0]  wb_id;
  logic [31:0] wb_rd;
  logic        wb_ack = 1'b0;
  logic        overflow;
  logic [2:0]  count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [34:0] sb_q[$];

  alu_wb_buffer #(.DEPTH(4), .ID_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .in_done(in_done), .in_id(in_id), .in_rd(in_rd),
    .unit_ready(unit_ready), .wb_valid(wb_valid), .wb_id(wb_id), .wb_rd(wb_rd),
    .wb_ack(wb_ack), .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one cycle of inputs just after the rising edge; queue the result if it will be delivered.
  task automatic step(input logic done, input logic [2:0] id, input logic [31:0] rd,
                      input logic ack, input logic store);
    @(posedge clk);
    #1;
    in_done = done;
    in_id   = id;
    in_rd   = rd;
    wb_ack  = ack;
    if (store) sb_q.push_back({id, rd});
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // Monitor: every presented head must match the oldest outstanding result.
  always @(negedge clk) begin
    if (rst && wb_valid) begin
      if (sb_q.size() == 0) begin
        total_cnt++;
        $display("FAIL sb_unexpected: got id=%0d rd=%h expected no valid output", wb_id, wb_rd);
      end else begin
        chk("sb_head", 64'({wb_id, wb_rd}), 64'(sb_q[0]));
        if (wb_ack) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(wb_valid), 64'd0);
    chk("rst_ready", 64'(unit_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_id", 64'(wb_id), 64'd0);
    chk("rst_rd", 64'(wb_rd), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Two pushes, held, then acked
    step(1'b1, 3'd1, 32'hDEADBEEF, 1'b0, 1'b1);
    @(negedge clk);
    chk("lat_valid_c1", 64'(wb_valid), BYP ? 64'd1 : 64'd0);
    step(1'b1, 3'd2, 32'h12345678, 1'b0, 1'b1);
    @(negedge clk);
    chk("lat_valid_c2", 64'(wb_valid), 64'd1);
    chk("lat_id_c2", 64'(wb_id), 64'd1);
    idle();
    @(negedge clk);
    chk("two_count", 64'(count), 64'd2);
    chk("two_hold_rd", 64'(wb_rd), 64'hDEADBEEF);
    step(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("ack1_id", 64'(wb_id), 64'd1);
    step(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("ack2_id", 64'(wb_id), 64'd2);
    idle();
    @(negedge clk);
    chk("drained_valid", 64'(wb_valid), 64'd0);
    chk("drained_count", 64'(count), 64'd0);

    // Fill to DEPTH, then overflow
    step(1'b1, 3'd4, 32'hA0000004, 1'b0, 1'b1);
    step(1'b1, 3'd5, 32'hA0000005, 1'b0, 1'b1);
    step(1'b1, 3'd6, 32'hA0000006, 1'b0, 1'b1);
    step(1'b1, 3'd0, 32'hA0000000, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(unit_ready), 64'd0);
    chk("full_ovf", 64'(overflow), 64'd0);
    step(1'b1, 3'd7, 32'hBAD00007, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_count", 64'(count), 64'd4);
    chk("ovf_head", 64'(wb_id), 64'd4);
    repeat (4) step(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    chk("ovf_drain_count", 64'(count), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    chk("ovf_drain_ready", 64'(unit_ready), 64'd1);

    // Streaming push+ack, ids wrap
    step(1'b1, 3'd0, 32'hC0DE0000, 1'b0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 3'(i % 8), 32'hC0DE0000 + 32'(i), 1'b1, 1'b1);
      @(negedge clk);
      chk("stream_count", 64'(count), 64'd1);
    end
    step(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    chk("stream_end_count", 64'(count), 64'd0);

    // Asynchronous reset mid-operation
    step(1'b1, 3'd1, 32'h11111111, 1'b0, 1'b1);
    step(1'b1, 3'd2, 32'h22222222, 1'b0, 1'b1);
    step(1'b1, 3'd3, 32'h33333333, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    chk("pre_rst_count", 64'(count), 64'd3);
    #2 rst = 1'b0;
    #1;
    chk("async_valid", 64'(wb_valid), 64'd0);
    chk("async_count", 64'(count), 64'd0);
    sb_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_count", 64'(count), 64'd0);
    chk("post_rst_ready", 64'(unit_ready), 64'd1);
    chk("post_rst_ovf", 64'(overflow), 64'd0);

    // Empty buffer, result acked in its issue cycle
    step(1'b1, 3'd3, 32'hA5A5A5A5, 1'b1, 1'b1);
    @(negedge clk);
    chk("byp_valid", 64'(wb_valid), BYP ? 64'd1 : 64'd0);
    if (BYP) begin
      chk("byp_id", 64'(wb_id), 64'd3);
      chk("byp_rd", 64'(wb_rd), 64'hA5A5A5A5);
    end
    step(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("byp_next_count", 64'(count), BYP ? 64'd0 : 64'd1);
    chk("byp_next_valid", 64'(wb_valid), BYP ? 64'd0 : 64'd1);
    idle();
    @(negedge clk);
    chk("byp_final_count", 64'(count), 64'd0);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
